// File: rtl/ascon_absorb_seq.sv
// Ascon absorb sequencer: latches a job, fetches one 128-bit beat per rate block,
// waits out the permutation settle time and strobes process_en once per block.
module ascon_absorb_seq #(
  parameter int unsigned PERM_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   sel_type_i,
  input  logic [31:0]  data_length_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [1:0]   sel_type_o,
  output logic [31:0]  data_length_o,
  output logic [31:0]  data_position_o,
  output logic [127:0] data_o,
  output logic         process_en,
  output logic         state_sel,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(PERM_LAT - 1);

  state_t       state_q, state_d;
  logic [1:0]   sel_q, sel_d;
  logic [31:0]  len_q, len_d;
  logic [31:0]  pos_q, pos_d;
  logic [127:0] data_q, data_d;
  logic         ssel_q, ssel_d;
  logic [3:0]   cnt_q, cnt_d;

  logic [31:0]  rate;
  logic [31:0]  rem;

  // Unsigned 32-bit remaining-byte count; position only advances while rem >= rate.
  assign rate = (sel_q == 2'b00) ? 32'd16 : 32'd8;
  assign rem  = len_q - pos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 2'b00;
      len_q   <= 32'd0;
      pos_q   <= 32'd0;
      data_q  <= 128'd0;
      ssel_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      pos_q   <= pos_d;
      data_q  <= data_d;
      ssel_q  <= ssel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    len_d      = len_q;
    pos_d      = pos_q;
    data_d     = data_q;
    ssel_d     = ssel_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    process_en = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d  = sel_type_i;
          len_d  = data_length_i;
          pos_d  = 32'd0;
          ssel_d = 1'b0;
          if (data_length_i != 32'd0) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_FETCH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_EXEC: begin
        process_en = 1'b1;
        if (rem < rate) begin
          state_d = S_DONE;
        end else begin
          pos_d  = pos_q + rate;
          ssel_d = 1'b1;
          // A block that lands exactly on the end still needs a padding-only step.
          if (rem == rate) begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy            = (state_q != S_IDLE);
  assign sel_type_o      = sel_q;
  assign data_length_o   = len_q;
  assign data_position_o = pos_q;
  assign data_o          = data_q;
  assign state_sel       = ssel_q;

endmodule
